// File: rtl/poly_tomsg_pkg.sv
// Shared constants and types for the NewHope message decoder (poly_tomsg).
package poly_tomsg_pkg;

    localparam int NH_Q       = 12289;
    localparam int NH_Q_HALF  = 6144;
    localparam int NH_TH_512  = 6144;
    localparam int NH_TH_1024 = 12289;

    typedef logic [15:0] coeff_t;
    typedef logic [12:0] dist_t;
    typedef logic [14:0] sum_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic sum_t threshold(input int n);
        return (n == 1024) ? sum_t'(NH_TH_1024) : sum_t'(NH_TH_512);
    endfunction

endpackage

// File: rtl/poly_tomsg_if.sv
// Poly RAM read ports and message-buffer write port seen by poly_tomsg.
interface poly_tomsg_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] ram_addra;
    logic [ADDR_W-1:0] ram_addrb;
    logic [15:0]       ram_doa;
    logic [15:0]       ram_dob;
    logic              msg_we;
    logic [4:0]        msg_addr;
    logic [7:0]        msg_din;

    modport master (
        output ram_addra, ram_addrb, msg_we, msg_addr, msg_din,
        input  ram_doa, ram_dob
    );

    modport slave (
        input  ram_addra, ram_addrb, msg_we, msg_addr, msg_din,
        output ram_doa, ram_dob
    );
endinterface

// File: rtl/poly_tomsg_flipabs.sv
// Freeze a coefficient from [0,2Q) into [0,Q), then take its distance from Q/2.
module poly_tomsg_flipabs
    import poly_tomsg_pkg::*;
#(
    parameter int Q = NH_Q
) (
    input  coeff_t x,
    output dist_t  d
);
    coeff_t x_frz;
    coeff_t r;
    coeff_t m;

    always_comb begin
        x_frz = (x >= coeff_t'(Q)) ? x - coeff_t'(Q) : x;
        r     = x_frz - coeff_t'(NH_Q_HALF);
        m     = {16{r[15]}};
        d     = dist_t'((r + m) ^ m);
    end
endmodule

// File: rtl/poly_tomsg.sv
// Streams coefficient pairs (or quads for N=1024) out of poly RAM, thresholds the
// folded distance sum and packs one message bit per sum into 32 bytes.
module poly_tomsg
    import poly_tomsg_pkg::*;
#(
    parameter int N      = 512,
    parameter int ADDR_W = 9,
    parameter int Q      = NH_Q
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    output logic done,
    poly_tomsg_if.master bus
);
    localparam int   CW  = ADDR_W - 1;
    localparam bit   BIG = (N == 1024);
    localparam sum_t TH  = threshold(N);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [1:0]    drain_q, drain_d;
    logic          done_q, done_d;
    logic          en_prev_q, en_prev_d;
    coeff_t        hold_a_q, hold_a_d;
    coeff_t        hold_b_q, hold_b_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    sum_t          partial_q, partial_d;
    sum_t          s_q, s_d;
    logic          s_valid_q, s_valid_d;
    logic [6:0]    shift_q, shift_d;
    logic [7:0]    bit_cnt_q, bit_cnt_d;
    logic          msg_we_q, msg_we_d;
    logic [4:0]    msg_addr_q, msg_addr_d;
    logic [7:0]    msg_din_q, msg_din_d;

    logic [ADDR_W-1:0] addra, addrb;
    coeff_t            da_raw, db_raw;
    dist_t             dist_a, dist_b;
    sum_t              pair_sum;
    logic              new_bit;

    // N=1024 alternates between the low and high halves for the same bit index
    if (BIG) begin : g_addr_1024
        assign addra = {cyc_q[0], 1'b0, cyc_q[CW-1:1]};
        assign addrb = {cyc_q[0], 1'b1, cyc_q[CW-1:1]};
    end else begin : g_addr_512
        assign addra = {1'b0, cyc_q};
        assign addrb = {1'b1, cyc_q};
    end

    // The RAM keeps reading while en is low, so the last valid read data is held
    // until the pipeline is allowed to consume it.
    assign da_raw = en_prev_q ? bus.ram_doa : hold_a_q;
    assign db_raw = en_prev_q ? bus.ram_dob : hold_b_q;

    poly_tomsg_flipabs #(.Q(Q)) u_flipabs_a (.x(da_raw), .d(dist_a));
    poly_tomsg_flipabs #(.Q(Q)) u_flipabs_b (.x(db_raw), .d(dist_b));

    assign pair_sum = sum_t'(dist_a) + sum_t'(dist_b);
    assign new_bit  = (s_q < TH);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        en_prev_d  = en;
        hold_a_d   = da_raw;
        hold_b_d   = db_raw;
        rd_valid_d = (state_q == ST_READ);
        rd_last_d  = BIG ? cyc_q[0] : 1'b1;
        partial_d  = partial_q;
        s_d        = s_q;
        s_valid_d  = 1'b0;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        msg_we_d   = 1'b0;
        msg_addr_d = msg_addr_q;
        msg_din_d  = msg_din_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_READ;
                    cyc_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_READ: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == '1) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_valid_q) begin
            if (rd_last_q) begin
                s_d       = pair_sum + (BIG ? partial_q : sum_t'(0));
                s_valid_d = 1'b1;
            end else begin
                partial_d = pair_sum;
            end
        end

        // Bits enter at the top so bit 0 of each byte ends up in position 0
        if (s_valid_q) begin
            shift_d   = {new_bit, shift_q[6:1]};
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q[2:0] == 3'd7) begin
                msg_we_d   = 1'b1;
                msg_addr_d = bit_cnt_q[7:3];
                msg_din_d  = {new_bit, shift_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
            en_prev_q  <= 1'b0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            partial_q  <= '0;
            s_q        <= '0;
            s_valid_q  <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            msg_we_q   <= 1'b0;
            msg_addr_q <= '0;
            msg_din_q  <= '0;
        end else begin
            en_prev_q <= en_prev_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
            if (en) begin
                state_q    <= state_d;
                cyc_q      <= cyc_d;
                drain_q    <= drain_d;
                done_q     <= done_d;
                rd_valid_q <= rd_valid_d;
                rd_last_q  <= rd_last_d;
                partial_q  <= partial_d;
                s_q        <= s_d;
                s_valid_q  <= s_valid_d;
                shift_q    <= shift_d;
                bit_cnt_q  <= bit_cnt_d;
                msg_we_q   <= msg_we_d;
                msg_addr_q <= msg_addr_d;
                msg_din_q  <= msg_din_d;
            end
        end
    end

    assign done          = done_q;
    assign bus.ram_addra = (state_q == ST_READ) ? addra : '0;
    assign bus.ram_addrb = (state_q == ST_READ) ? addrb : '0;
    assign bus.msg_we    = msg_we_q;
    assign bus.msg_addr  = msg_addr_q;
    assign bus.msg_din   = msg_din_q;
endmodule

// File: tb/tb_poly_tomsg.sv
// Bench for poly_tomsg: N=512 and N=1024 instances against a RAM model and a
// plain-arithmetic reference decoder.
module tb_poly_tomsg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;
    logic start_s, start_b;
    logic done_s, done_b;

    poly_tomsg_if #(.ADDR_W(9))  bus_s ();
    poly_tomsg_if #(.ADDR_W(10)) bus_b ();

    poly_tomsg #(.N(512), .ADDR_W(9), .Q(12289)) dut_s (
        .clk(clk), .rst(rst), .en(en), .start(start_s), .done(done_s), .bus(bus_s.master)
    );
    poly_tomsg #(.N(1024), .ADDR_W(10), .Q(12289)) dut_b (
        .clk(clk), .rst(rst), .en(en), .start(start_b), .done(done_b), .bus(bus_b.master)
    );

    logic [15:0] mem [2][1024];

    // Free-running synchronous RAM, one cycle of read latency, never gated by en
    always @(posedge clk) begin
        bus_s.ram_doa <= mem[0][bus_s.ram_addra];
        bus_s.ram_dob <= mem[0][bus_s.ram_addrb];
        bus_b.ram_doa <= mem[1][bus_b.ram_addra];
        bus_b.ram_dob <= mem[1][bus_b.ram_addrb];
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [7:0] got [2][32];
    int wr_cnt [2]    = '{0, 0};
    int order_err [2] = '{0, 0};
    int exp_addr [2]  = '{0, 0};
    int done_cnt [2]  = '{0, 0};
    int done_cyc [2]  = '{0, 0};
    int last_we [2]   = '{0, 0};

    // A write held across a frozen stretch is the same write, so only en-high cycles log it
    always @(negedge clk) begin
        if (!rst) begin
            exp_addr[0] = 0;
            exp_addr[1] = 0;
        end
        if (en && bus_s.msg_we) begin
            if (int'(bus_s.msg_addr) != exp_addr[0]) order_err[0]++;
            exp_addr[0] = (exp_addr[0] + 1) % 32;
            got[0][bus_s.msg_addr] = bus_s.msg_din;
            wr_cnt[0]++;
            last_we[0] = cycle;
        end
        if (en && bus_b.msg_we) begin
            if (int'(bus_b.msg_addr) != exp_addr[1]) order_err[1]++;
            exp_addr[1] = (exp_addr[1] + 1) % 32;
            got[1][bus_b.msg_addr] = bus_b.msg_din;
            wr_cnt[1]++;
            last_we[1] = cycle;
        end
        if (done_s) begin
            done_cnt[0]++;
            done_cyc[0] = cycle;
        end
        if (done_b) begin
            done_cnt[1]++;
            done_cyc[1] = cycle;
        end
    end

    int checks = 0;
    int failures = 0;
    int base_wr [2];
    int base_done [2];
    int base_ord [2];
    logic [7:0] exp_bytes [32];

    task automatic checkValue(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int fold(input int x);
        int xm;
        xm = x % 12289;
        return (xm > 6144) ? xm - 6144 : 6144 - xm;
    endfunction

    // Reference decoder straight from the arithmetic definition of the message
    function automatic void refModel(input int d);
        int s;
        for (int k = 0; k < 32; k++) exp_bytes[k] = 8'h00;
        for (int b = 0; b < 256; b++) begin
            if (d == 1)
                s = fold(int'(mem[1][b])) + fold(int'(mem[1][b + 256]))
                  + fold(int'(mem[1][b + 512])) + fold(int'(mem[1][b + 768]));
            else
                s = fold(int'(mem[0][b])) + fold(int'(mem[0][b + 256]));
            if (s < ((d == 1) ? 12289 : 6144)) exp_bytes[b / 8][b % 8] = 1'b1;
        end
    endfunction

    task automatic fillUniform(input int d, input int lo, input int hi);
        for (int a = 0; a < 1024; a++) mem[d][a] = 16'((a < 512) ? lo : hi);
    endtask

    task automatic fillRandom(input int d);
        for (int a = 0; a < 1024; a++) mem[d][a] = 16'($urandom_range(0, 2 * 12289 - 1));
    endtask

    task automatic applyStimulus(input int d, input int frz_at, input int frz_len, output int s_cyc);
        base_wr[d]   = wr_cnt[d];
        base_done[d] = done_cnt[d];
        base_ord[d]  = order_err[d];
        @(posedge clk); #1;
        s_cyc = cycle;
        if (d == 0) start_s = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        start_b = 1'b0;
        if (frz_len > 0) begin
            repeat (frz_at) @(posedge clk);
            #1 en = 1'b0;
            repeat (frz_len) @(posedge clk);
            #1 en = 1'b1;
        end
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (done_cnt[d] != base_done[d]) break;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int d, input int s_cyc, input int exp_lat);
        checkValue({name, "/writes"}, wr_cnt[d] - base_wr[d], 32);
        checkValue({name, "/addr_order"}, order_err[d] - base_ord[d], 0);
        for (int k = 0; k < 32; k++)
            checkValue($sformatf("%s/byte%0d", name, k), int'(got[d][k]), int'(exp_bytes[k]));
        checkValue({name, "/done_pulses"}, done_cnt[d] - base_done[d], 1);
        checkValue({name, "/done_latency"}, done_cyc[d] - s_cyc, exp_lat);
        checkValue({name, "/last_we_latency"}, last_we[d] - s_cyc, exp_lat - 1);
    endtask

    typedef struct {
        int         dut;
        int         lo;
        int         hi;
        logic [7:0] exp_byte;
        int         exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int s_cyc;

        vecs[0] = '{0, 6144,  6144,  8'hFF, 260};
        vecs[1] = '{0, 0,     0,     8'h00, 260};
        vecs[2] = '{0, 18433, 18433, 8'hFF, 260};
        vecs[3] = '{0, 12288, 12288, 8'h00, 260};
        vecs[4] = '{1, 6144,  0,     8'hFF, 516};
        vecs[5] = '{1, 0,     0,     8'h00, 516};

        rst = 1'b0;
        en = 1'b1;
        start_s = 1'b0;
        start_b = 1'b0;
        fillUniform(0, 0, 0);
        fillUniform(1, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkValue("reset/done", int'(done_s), 0);
        checkValue("reset/msg_we", int'(bus_s.msg_we), 0);
        checkValue("reset/addra", int'(bus_s.ram_addra), 0);
        checkValue("reset/addrb", int'(bus_s.ram_addrb), 0);
        checkValue("reset/msg_addr", int'(bus_s.msg_addr), 0);
        checkValue("reset/msg_din", int'(bus_s.msg_din), 0);
        checkValue("reset/done_1024", int'(done_b), 0);
        @(posedge clk); #1 rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fillUniform(vecs[v].dut, vecs[v].lo, vecs[v].hi);
            for (int k = 0; k < 32; k++) exp_bytes[k] = vecs[v].exp_byte;
            applyStimulus(vecs[v].dut, 0, 0, s_cyc);
            checkOutput($sformatf("vec%0d", v), vecs[v].dut, s_cyc, vecs[v].exp_lat);
        end

        $display("[TB] threshold boundary on bit 0");
        fillUniform(0, 0, 0);
        mem[0][0]   = 16'd9216;
        mem[0][256] = 16'd3072;
        for (int k = 0; k < 32; k++) exp_bytes[k] = 8'h00;
        applyStimulus(0, 0, 0, s_cyc);
        checkOutput("thresh_eq", 0, s_cyc, 260);
        mem[0][256] = 16'd3073;
        exp_bytes[0] = 8'h01;
        applyStimulus(0, 0, 0, s_cyc);
        checkOutput("thresh_below", 0, s_cyc, 260);

        $display("[TB] clock enable held low mid-read");
        fillRandom(0);
        refModel(0);
        applyStimulus(0, 60, 10, s_cyc);
        checkOutput("en_freeze", 0, s_cyc, 270);

        $display("[TB] reset mid-read");
        fillRandom(0);
        refModel(0);
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkValue("abort/done", int'(done_s), 0);
        checkValue("abort/msg_we", int'(bus_s.msg_we), 0);
        @(posedge clk); #1 rst = 1'b1;
        base_wr[0]   = wr_cnt[0];
        base_done[0] = done_cnt[0];
        repeat (300) @(negedge clk);
        checkValue("abort/no_writes", wr_cnt[0] - base_wr[0], 0);
        checkValue("abort/no_done", done_cnt[0] - base_done[0], 0);
        applyStimulus(0, 0, 0, s_cyc);
        checkOutput("after_abort", 0, s_cyc, 260);

        $display("[TB] random coefficients");
        for (int r = 0; r < 4; r++) begin
            fillRandom(0);
            refModel(0);
            applyStimulus(0, 0, 0, s_cyc);
            checkOutput($sformatf("rand512_%0d", r), 0, s_cyc, 260);
        end
        for (int r = 0; r < 2; r++) begin
            fillRandom(1);
            refModel(1);
            applyStimulus(1, 0, 0, s_cyc);
            checkOutput($sformatf("rand1024_%0d", r), 1, s_cyc, 516);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
